// File: rtl/fir_pkg.sv
// Shared types and width helpers for the FIR output post-processing path.
// No logic, no latency.
// No flow control; types and constants only.
package fir_pkg;

   typedef enum logic [1:0] {
      RND_TRUNC      = 2'd0,
      RND_HALF_UP    = 2'd1,
      RND_CONVERGENT = 2'd2
   } round_mode_e;

   // Width of the value left after dropping `shift` LSBs from a sign-extended in_w-bit sum.
   function automatic int satWidth(input int in_w, input int shift);
      return in_w + 1 - shift;
   endfunction

endpackage

// File: rtl/fir_out_decim_round_if.sv
// Sample stream bundle: qualifier plus signed data word.
// No latency; wires only.
// No backpressure: the consumer must take every sample that is valid.
interface fir_out_decim_round_if #(
   parameter int W = 16
);
   logic         vld;
   logic [W-1:0] dat;

   modport master (output vld, output dat);
   modport slave  (input  vld, input  dat);
endinterface

// File: rtl/fir_out_decim_round_round_sat.sv
// Round (drop SHIFT LSBs) and saturate a signed sample to OUTPUT_WIDTH, with a valid pipeline.
// Latency 2 registers: stage 1 holds the biased sum, stage 2 holds the clamped result.
// No backpressure; sat_evt is combinational and lines up with the edge that loads out_dat.
module fir_round_sat
   import fir_pkg::*;
#(
   parameter int INPUT_WIDTH  = 33,
   parameter int OUTPUT_WIDTH = 16,
   parameter int SHIFT        = 16,
   parameter int ROUND_MODE   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_vld,
   input  logic [INPUT_WIDTH-1:0]  in_dat,
   output logic                    out_vld,
   output logic [OUTPUT_WIDTH-1:0] out_dat,
   output logic                    sat_evt
);

   localparam int SW = INPUT_WIDTH + 1;
   localparam int QW = satWidth(INPUT_WIDTH, SHIFT);
   localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [SW-1:0] HALF = (SHIFT > 0) ? (SW'(1) << HS) : '0;
   localparam round_mode_e MODE = round_mode_e'(ROUND_MODE[1:0]);

   if (SHIFT < 0 || SHIFT >= INPUT_WIDTH) begin : g_bad_shift
      $error("fir_round_sat: SHIFT must be in 0..INPUT_WIDTH-1");
   end
   if (ROUND_MODE < 0 || ROUND_MODE > 2) begin : g_bad_mode
      $error("fir_round_sat: ROUND_MODE must be 0, 1 or 2");
   end

   logic [SW-1:0]           din_ext;
   logic [SW-1:0]           bias;
   logic [SW-1:0]           sum_d, sum_q;
   logic                    s1_vld_d, s1_vld_q;
   logic [QW-1:0]           q;
   logic [OUTPUT_WIDTH-1:0] q_fit;
   logic                    q_sat;
   logic [OUTPUT_WIDTH-1:0] dout_d, dout_q;
   logic                    out_vld_d, out_vld_q;

   // Stage 1: add the rounding bias; one extra bit of headroom means the add never wraps
   always_comb begin
      din_ext  = {in_dat[INPUT_WIDTH-1], in_dat};
      bias     = '0;
      if (SHIFT > 0) begin
         case (MODE)
            RND_HALF_UP:    bias = HALF;
            // half minus one, plus the LSB that survives, pushes exact ties to the even result
            RND_CONVERGENT: bias = HALF - SW'(1) + SW'(in_dat[SHIFT]);
            default:        bias = '0;
         endcase
      end
      sum_d    = in_vld ? (din_ext + bias) : sum_q;
      s1_vld_d = in_vld;
   end

   // Stage 2 front end: arithmetic shift of the biased sum keeps only the integer part
   always_comb begin
      q = QW'($signed(sum_q) >>> SHIFT);
   end

   if (QW > OUTPUT_WIDTH) begin : g_clamp
      // Clamp when the bits above the output range are not all copies of the sign
      always_comb begin
         q_sat = 1'b0;
         q_fit = q[OUTPUT_WIDTH-1:0];
         if (!q[QW-1] && (|q[QW-2:OUTPUT_WIDTH-1])) begin
            q_sat = 1'b1;
            q_fit = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
         end else if (q[QW-1] && !(&q[QW-2:OUTPUT_WIDTH-1])) begin
            q_sat = 1'b1;
            q_fit = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
         end
      end
   end else begin : g_ext
      // Narrow result always fits; just sign-extend
      always_comb begin
         q_sat = 1'b0;
         q_fit = OUTPUT_WIDTH'(signed'(q));
      end
   end

   // Stage 2 register inputs: output word holds between samples
   always_comb begin
      dout_d    = s1_vld_q ? q_fit : dout_q;
      out_vld_d = s1_vld_q;
      sat_evt   = s1_vld_q & q_sat;
   end

   // Both pipeline stages; reset drops anything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q     <= '0;
         s1_vld_q  <= 1'b0;
         dout_q    <= '0;
         out_vld_q <= 1'b0;
      end else begin
         sum_q     <= sum_d;
         s1_vld_q  <= s1_vld_d;
         dout_q    <= dout_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign out_vld = out_vld_q;
   assign out_dat = dout_q;

endmodule

// File: rtl/fir_out_decim_round.sv
// Decimate the FIR result stream by DECIM, then round/saturate it; sticky clamp flag.
// Latency 2 registers from an accepted kept sample to valid_out.
// No backpressure: every valid input is accepted; dropped samples never reach the output.
module fir_out_decim_round
   import fir_pkg::*;
#(
   parameter int INPUT_WIDTH  = 33,
   parameter int OUTPUT_WIDTH = 16,
   parameter int SHIFT        = 16,
   parameter int DECIM        = 1,
   parameter int ROUND_MODE   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   fir_out_decim_round_if.slave     in_if,
   fir_out_decim_round_if.master    out_if,
   input  logic                     sat_clr,
   output logic                     sat_flag
);

   if (DECIM < 1) begin : g_bad_decim
      $error("fir_out_decim_round: DECIM must be >= 1");
   end

   localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

   logic [CW-1:0]           cnt_d, cnt_q;
   logic                    keep;
   logic                    rs_vld;
   logic [OUTPUT_WIDTH-1:0] rs_dat;
   logic                    rs_sat;
   logic                    sat_flag_d, sat_flag_q;

   // Decimation phase advances per accepted sample; phase 0 marks the kept one
   always_comb begin
      cnt_d = cnt_q;
      if (in_if.vld) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      end
      keep = in_if.vld & (cnt_q == '0);
   end

   fir_round_sat #(
      .INPUT_WIDTH  (INPUT_WIDTH),
      .OUTPUT_WIDTH (OUTPUT_WIDTH),
      .SHIFT        (SHIFT),
      .ROUND_MODE   (ROUND_MODE)
   ) u_round_sat (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (keep),
      .in_dat  (in_if.dat),
      .out_vld (rs_vld),
      .out_dat (rs_dat),
      .sat_evt (rs_sat)
   );

   // Sticky clamp flag: a new clamp beats a coincident clear
   always_comb begin
      sat_flag_d = rs_sat | (sat_flag_q & ~sat_clr);
   end

   // Counter and flag state
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         sat_flag_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         sat_flag_q <= sat_flag_d;
      end
   end

   assign out_if.vld = rs_vld;
   assign out_if.dat = rs_dat;
   assign sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_fir_out_decim_round.sv
// Bench for fir_out_decim_round: four instances (modes 0/1/2 at DECIM=1, mode 1 at DECIM=3)
// share one input stream and are checked every cycle against an arithmetic reference model.
// No backpressure to model; hand-computed literals pin the model's rounding and clamping.
module tb_fir_out_decim_round;

   localparam int IW = 33;
   localparam int OW = 16;
   localparam int SH = 16;
   localparam int N  = 4;
   localparam longint MAXP = (longint'(1) << (OW - 1)) - 1;
   localparam longint MINN = -(longint'(1) << (OW - 1));

   logic clk = 1'b0;
   logic rst;
   logic sat_clr;

   always #5 clk = ~clk;

   fir_out_decim_round_if #(.W(IW)) in_if ();

   logic          vo [N];
   logic [OW-1:0] dv [N];
   logic          sf [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      fir_out_decim_round_if #(.W(OW)) out_if ();
      fir_out_decim_round #(
         .INPUT_WIDTH  (IW),
         .OUTPUT_WIDTH (OW),
         .SHIFT        (SH),
         .DECIM        ((g == 3) ? 3 : 1),
         .ROUND_MODE   ((g == 3) ? 1 : g)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .in_if    (in_if),
         .out_if   (out_if),
         .sat_clr  (sat_clr),
         .sat_flag (sf[g])
      );
      assign vo[g] = out_if.vld;
      assign dv[g] = out_if.dat;
   end

   int n_chk  = 0;
   int n_pass = 0;

   function automatic void check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   function automatic int mode_of(input int i);
      return (i == 3) ? 1 : i;
   endfunction

   function automatic int decim_of(input int i);
      return (i == 3) ? 3 : 1;
   endfunction

   function automatic longint sdv(input int i);
      return longint'($signed(dv[i]));
   endfunction

   // Integer rounding of d / 2^SH by floor division plus remainder inspection
   function automatic longint round_ref(input longint d, input int mode);
      longint one, half, fl, r, res;
      one  = longint'(1) << SH;
      half = one / 2;
      fl   = d / one;
      if ((d % one) != 0 && d < 0) fl = fl - 1;
      r    = d - fl * one;
      res  = fl;
      if (mode == 1) begin
         if (r >= half) res = fl + 1;
      end else if (mode == 2) begin
         if (r > half) res = fl + 1;
         else if (r == half) res = fl + (fl & 1);
      end
      return res;
   endfunction

   // Reference model state: one result becomes visible one edge after acceptance
   bit     live = 1'b0;
   int     m_cnt    [N];
   bit     m_vld    [N];
   longint m_dout   [N];
   bit     m_sat    [N];
   bit     pend_v   [N];
   longint pend_val [N];
   bit     pend_sat [N];

   always @(posedge clk) begin
      longint qv;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            live        = 1'b1;
            m_cnt[i]    = 0;
            m_vld[i]    = 1'b0;
            m_dout[i]   = 0;
            m_sat[i]    = 1'b0;
            pend_v[i]   = 1'b0;
         end else begin
            m_vld[i] = pend_v[i];
            if (pend_v[i]) m_dout[i] = pend_val[i];
            if (pend_v[i] && pend_sat[i]) m_sat[i] = 1'b1;
            else if (sat_clr) m_sat[i] = 1'b0;
            pend_v[i] = 1'b0;
            if (in_if.vld) begin
               if (m_cnt[i] == 0) begin
                  qv = round_ref(longint'($signed(in_if.dat)), mode_of(i));
                  pend_v[i]   = 1'b1;
                  pend_sat[i] = (qv > MAXP) || (qv < MINN);
                  pend_val[i] = (qv > MAXP) ? MAXP : (qv < MINN) ? MINN : qv;
               end
               m_cnt[i] = (m_cnt[i] + 1) % decim_of(i);
            end
         end
      end
   end

   // Every-cycle comparison of all instances against the model
   always @(negedge clk) begin
      if (live) begin
         for (int i = 0; i < N; i++) begin
            check($sformatf("dut%0d valid_out", i), longint'(vo[i]), longint'(m_vld[i]));
            check($sformatf("dut%0d dout", i), sdv(i), m_dout[i]);
            check($sformatf("dut%0d sat_flag", i), longint'(sf[i]), longint'(m_sat[i]));
         end
      end
   end

   // Output collectors for the decimation and throughput scenarios
   bit     dec_rec = 1'b0;
   longint dec_got [$];
   bit     bb_rec  = 1'b0;
   int     bb_cnt  = 0;

   always @(negedge clk) begin
      if (dec_rec && vo[3]) dec_got.push_back(sdv(3));
      if (bb_rec && vo[0]) bb_cnt++;
   end

   task automatic step(input bit v, input longint d, input bit r, input bit c);
      @(posedge clk);
      #1;
      in_if.vld = v;
      in_if.dat = d[IW-1:0];
      rst       = r;
      sat_clr   = c;
   endtask

   // One isolated sample; checks modes 0..2 exactly two cycles after it was presented
   task automatic lit3(input string nm, input longint d,
                       input longint e0, input longint e1, input longint e2);
      longint e [3];
      e = '{e0, e1, e2};
      step(1'b1, d, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s mode%0d dout", nm, k), sdv(k), e[k]);
         check($sformatf("%s mode%0d valid", nm, k), longint'(vo[k]), 1);
         check($sformatf("%s mode%0d sat", nm, k), longint'(sf[k]), 0);
      end
   endtask

   function automatic longint rand_sample();
      longint v;
      v = longint'($signed({$urandom, $urandom})) >>> (31 + $urandom_range(31, 0));
      if ($urandom_range(3, 0) == 0) v = {v[63:16], 16'h8000};
      return v;
   endfunction

   initial begin
      longint exp_d [3];
      exp_d = '{1, 4, 7};
      in_if.vld = 1'b0;
      in_if.dat = '0;
      rst       = 1'b1;
      sat_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset valid_out", longint'(vo[0]), 0);
      check("reset dout", sdv(1), 0);
      check("reset sat_flag", longint'(sf[2]), 0);
      rst = 1'b0;

      // Rounding modes on positive ties and near-ties
      lit3("p1.5", 64'h18000, 1, 2, 2);
      lit3("p2.5", 64'h28000, 2, 3, 2);
      lit3("p1.99", 64'h1FFFF, 1, 2, 2);
      // Negative tie
      lit3("n1.5", -64'sh18000, -2, -1, -2);

      // Saturation high, then low, then clear, then clear colliding with a clamp
      step(1'b1, 64'h7FFF8000, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      @(posedge clk); #2;
      check("sat hi dout", sdv(1), 32767);
      check("sat hi flag", longint'(sf[1]), 1);
      check("sat hi valid", longint'(vo[1]), 1);
      step(1'b1, -(longint'(1) << 32), 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      @(posedge clk); #2;
      check("sat lo dout", sdv(1), -32768);
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b0);
      check("sat clr flag", longint'(sf[1]), 0);
      step(1'b1, 64'h7FFF8000, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b0);
      check("sat set wins flag", longint'(sf[1]), 1);
      check("sat set wins valid", longint'(vo[1]), 1);

      // Decimation by 3 with random gaps
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      dec_got.delete();
      dec_rec = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step(1'b1, longint'(k) * 64'h10000, 1'b0, 1'b0);
         repeat ($urandom_range(3, 0)) step(1'b0, 0, 1'b0, 1'b0);
      end
      repeat (4) step(1'b0, 0, 1'b0, 1'b0);
      dec_rec = 1'b0;
      check("decim pulse count", longint'(dec_got.size()), 3);
      for (int j = 0; j < 3; j++) begin
         check($sformatf("decim out%0d", j), (j < dec_got.size()) ? dec_got[j] : -999, exp_d[j]);
      end

      // Reset while a kept sample sits in stage 1
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b1, 64'h50000, 1'b0, 1'b0);
      step(1'b1, 64'h60000, 1'b1, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      check("midrst valid", longint'(vo[3]), 0);
      check("midrst dout", sdv(3), 0);
      check("midrst sat", longint'(sf[3]), 0);
      step(1'b1, 64'h30000, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      @(posedge clk); #2;
      check("post-rst kept valid", longint'(vo[3]), 1);
      check("post-rst kept dout", sdv(3), 3);

      // 100 back-to-back random samples
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      bb_cnt = 0;
      bb_rec = 1'b1;
      for (int k = 0; k < 100; k++) begin
         step(1'b1, rand_sample(), 1'b0, ($urandom_range(7, 0) == 0));
      end
      repeat (4) step(1'b0, 0, 1'b0, 1'b0);
      bb_rec = 1'b0;
      check("b2b output count", longint'(bb_cnt), 100);

      // Random valid toggling and clears
      for (int k = 0; k < 200; k++) begin
         step(1'($urandom_range(1, 0)), rand_sample(), 1'b0, ($urandom_range(7, 0) == 0));
      end
      repeat (4) step(1'b0, 0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
